// File: rtl/led_sweep_ctrl_if.sv
// Button input and LED/mode outputs shared between the sweep controller and its environment.
interface led_sweep_ctrl_if;
    logic       btn;
    logic [7:0] led;
    logic [1:0] mode;

    // Environment side: drives the raw button, observes LEDs and mode.
    modport master (
        output btn,
        input  led,
        input  mode
    );

    // Controller side.
    modport slave (
        input  btn,
        output led,
        output mode
    );
endinterface

// File: rtl/led_sweep_ctrl.sv
// Mode-sequenced 8-LED sweep: debounced button steps the mode FSM, which schedules a
// bouncing position counter and per-channel brightness into an 8-channel PWM.
module led_sweep_ctrl #(
    parameter int unsigned CTR_WIDTH     = 24,
    parameter int unsigned PWM_BITS      = 10,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    led_sweep_ctrl_if.slave sweep_if
);
    localparam int unsigned NUM_LED = 8;
    localparam logic [PWM_BITS-1:0]      PWM_MAX = {PWM_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX  = {DEBOUNCE_BITS{1'b1}};

    typedef enum logic [1:0] {
        MODE_SWEEP   = 2'd0,
        MODE_BREATHE = 2'd1,
        MODE_HOLD    = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_accepted;
    logic                     r_press;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    mode_e                    r_mode;
    mode_e                    w_mode_nxt;
    logic [CTR_WIDTH-1:0]     r_ctr;
    logic                     r_dir;
    logic [PWM_BITS-1:0]      r_pwm_ctr;
    logic [PWM_BITS-1:0]      r_b     [NUM_LED];
    logic [PWM_BITS-1:0]      w_b_nxt [NUM_LED];
    logic [NUM_LED-1:0]       r_led;
    logic [2:0]               w_seg;
    logic [PWM_BITS-1:0]      w_frac;
    logic [PWM_BITS-1:0]      w_breathe;

    assign w_seg     = r_ctr[CTR_WIDTH-1 -: 3];
    assign w_frac    = r_ctr[CTR_WIDTH-4 -: PWM_BITS];
    assign w_breathe = r_ctr[CTR_WIDTH-1 -: PWM_BITS];

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sweep_if.btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept the synced level after a full window of disagreement; pulse on accepted rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_accepted <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_accepted) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_cnt   <= '0;
                r_accepted <= r_sync2;
                r_press    <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_SWEEP;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Mode next-state: a press steps through the fixed ring.
    always_comb begin
        w_mode_nxt = r_mode;
        if (r_press) begin
            unique case (r_mode)
                MODE_SWEEP:   w_mode_nxt = MODE_BREATHE;
                MODE_BREATHE: w_mode_nxt = MODE_HOLD;
                MODE_HOLD:    w_mode_nxt = MODE_OFF;
                MODE_OFF:     w_mode_nxt = MODE_SWEEP;
            endcase
        end
    end

    // Bouncing position counter; the turnaround lands one count past the segment edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr <= '0;
            r_dir <= 1'b0;
        end else begin
            unique case (r_mode)
                MODE_SWEEP, MODE_BREATHE: begin
                    r_ctr <= r_dir ? (r_ctr - 1'b1) : (r_ctr + 1'b1);
                    if ((w_seg == 3'd7) && !r_dir) begin
                        r_dir <= 1'b1;
                    end else if ((w_seg == 3'd0) && r_dir) begin
                        r_dir <= 1'b0;
                    end
                end
                MODE_HOLD: begin
                end
                MODE_OFF: begin
                    r_ctr <= '0;
                    r_dir <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel brightness: cross-fade around the current segment, uniform ramp, or dark.
    always_comb begin
        for (int i = 0; i < int'(NUM_LED); i++) begin
            w_b_nxt[i] = '0;
            unique case (r_mode)
                MODE_BREATHE: w_b_nxt[i] = w_breathe;
                MODE_OFF:     w_b_nxt[i] = '0;
                default: begin
                    if ({1'b0, w_seg} == 4'(i)) begin
                        w_b_nxt[i] = PWM_MAX;
                    end else if ({1'b0, w_seg} == 4'(i - 1)) begin
                        w_b_nxt[i] = w_frac;
                    end else if ({1'b0, w_seg} == 4'(i + 1)) begin
                        w_b_nxt[i] = PWM_MAX - w_frac;
                    end
                end
            endcase
        end
    end

    // Brightness registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_LED); i++) begin
                r_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_LED); i++) begin
                r_b[i] <= w_b_nxt[i];
            end
        end
    end

    // Free-running PWM counter and registered LED compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_ctr <= '0;
            r_led     <= '0;
        end else begin
            r_pwm_ctr <= r_pwm_ctr + 1'b1;
            for (int i = 0; i < int'(NUM_LED); i++) begin
                r_led[i] <= (r_pwm_ctr < r_b[i]);
            end
        end
    end

    assign sweep_if.led  = r_led;
    assign sweep_if.mode = r_mode;
endmodule
